// File: rtl/psg_pkg.sv
// Shared constants and helpers for the SN76489 sound generator core:
// write-byte field positions, noise rate decode, attenuation table, LFSR seed.
package psg_pkg;

  // Write byte fields
  localparam int LATCH_BIT = 7;
  localparam int CH_MSB    = 6;
  localparam int CH_LSB    = 5;
  localparam int TYPE_BIT  = 4;

  localparam int TONE_BITS = 10;
  localparam int NUM_TONES = 3;
  localparam int NOISE_CH  = 3;

  // Noise flip-flop half-periods, in generator ticks
  localparam int NOISE_HALF_16 = 16;
  localparam int NOISE_HALF_32 = 32;
  localparam int NOISE_HALF_64 = 64;

  typedef enum logic [1:0] {
    RATE_16    = 2'b00,
    RATE_32    = 2'b01,
    RATE_64    = 2'b10,
    RATE_TONE2 = 2'b11
  } noise_rate_e;

  typedef enum logic {
    REG_TONE   = 1'b0,
    REG_VOLUME = 1'b1
  } reg_type_e;

  // Half-period for the noise rate counter. RATE_TONE2 does not use the
  // counter's edges, so it simply keeps the counter running at the fastest rate.
  function automatic logic [TONE_BITS-1:0] noise_period(input noise_rate_e rate);
    case (rate)
      RATE_32: return TONE_BITS'(NOISE_HALF_32);
      RATE_64: return TONE_BITS'(NOISE_HALF_64);
      default: return TONE_BITS'(NOISE_HALF_16);
    endcase
  endfunction

  // round((2^w-1) * 10^(-k/10)) for k<15, 0 for k=15. The 2 dB steps are held
  // as 16-bit binary fractions so the table stays integer-only.
  function automatic longint unsigned attn_lut(input int k, input int w);
    longint unsigned frac;
    longint unsigned full;
    case (k)
      0:       frac = 64'd65536;
      1:       frac = 64'd52058;
      2:       frac = 64'd41351;
      3:       frac = 64'd32846;
      4:       frac = 64'd26090;
      5:       frac = 64'd20724;
      6:       frac = 64'd16462;
      7:       frac = 64'd13076;
      8:       frac = 64'd10387;
      9:       frac = 64'd8250;
      10:      frac = 64'd6554;
      11:      frac = 64'd5206;
      12:      frac = 64'd4135;
      13:      frac = 64'd3285;
      14:      frac = 64'd2609;
      default: frac = 64'd0;
    endcase
    full = (64'd1 << w) - 64'd1;
    return (full * frac + 64'd32768) >> 16;
  endfunction

  // LFSR reset/reload value: a single one in the MSB.
  function automatic longint unsigned lfsr_seed(input int bits);
    return 64'd1 << (bits - 1);
  endfunction

endpackage

// File: rtl/psg_tone_channel.sv
// Square-wave generator: down-counter reloaded with period-1, output toggles
// on each reload. Periods of 0 or 1 hold the output high.
module psg_tone_channel
  import psg_pkg::*;
#(
  parameter int PERIOD_BITS = TONE_BITS
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   tick,
  input  logic [PERIOD_BITS-1:0] period,
  output logic                   state,
  output logic                   rise
);

  logic [PERIOD_BITS-1:0] count;
  logic [PERIOD_BITS-1:0] count_next;
  logic                   state_next;

  // Next counter/state on a generator tick; period is sampled only at reload.
  always_comb begin
    count_next = count;
    state_next = state;
    if (tick) begin
      if (period <= PERIOD_BITS'(1)) begin
        state_next = 1'b1;
        count_next = '0;
      end else if (count == '0) begin
        count_next = period - PERIOD_BITS'(1);
        state_next = ~state;
      end else begin
        count_next = count - PERIOD_BITS'(1);
      end
    end
  end

  // rise marks the tick on which the output goes 0->1 (used to clock the noise LFSR).
  assign rise = ~state & state_next;

  // Counter and output register.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
      state <= 1'b0;
    end else begin
      count <= count_next;
      state <= state_next;
    end
  end

endmodule

// File: rtl/psg_sn76489_core.sv
// SN76489-compatible PSG: three tone channels plus one noise channel,
// programmed through the native latch/data byte protocol.
module psg_sn76489_core
  import psg_pkg::*;
#(
  parameter int                   CLOCK_DIV           = 16,
  parameter int                   CHANNEL_OUTPUT_BITS = 8,
  parameter int                   LFSR_BITS           = 16,
  parameter logic [LFSR_BITS-1:0] LFSR_TAP_MASK       = LFSR_BITS'('h9)
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [7:0]                       data_in,
  input  logic                             write_strobe,
  output logic                             tick,
  output logic [4*CHANNEL_OUTPUT_BITS-1:0] channel_out,
  output logic [CHANNEL_OUTPUT_BITS+1:0]   mix_out
);

  localparam int W        = CHANNEL_OUTPUT_BITS;
  localparam int MW       = W + 2;
  localparam int PRE_BITS = (CLOCK_DIV > 1) ? $clog2(CLOCK_DIV) : 1;
  localparam logic [PRE_BITS-1:0]  PRE_LAST  = PRE_BITS'(CLOCK_DIV - 1);
  localparam logic [LFSR_BITS-1:0] LFSR_SEED = LFSR_BITS'(lfsr_seed(LFSR_BITS));

  // ---------------------------------------------------------------- prescaler
  logic [PRE_BITS-1:0] pre_count;

  assign tick = (pre_count == PRE_LAST);

  // Wrapping master-clock divider; with CLOCK_DIV=1 it stays at 0 and ticks every cycle.
  always_ff @(posedge clk) begin
    if (reset)     pre_count <= '0;
    else if (tick) pre_count <= '0;
    else           pre_count <= pre_count + PRE_BITS'(1);
  end

  // ------------------------------------------------------------ register file
  logic [3:0]           attn      [4];
  logic [TONE_BITS-1:0] tone_freq [NUM_TONES];
  logic [2:0]           noise_ctrl;
  logic [1:0]           latch_ch;
  reg_type_e            latch_type;

  logic      is_latch;
  logic [1:0] wr_ch;
  reg_type_e wr_type;
  logic      noise_wr;

  // A latch byte supplies its own channel/type; a data byte reuses the stored ones.
  assign is_latch = data_in[LATCH_BIT];
  assign wr_ch    = is_latch ? data_in[CH_MSB:CH_LSB] : latch_ch;
  assign wr_type  = is_latch ? reg_type_e'(data_in[TYPE_BIT]) : latch_type;
  assign noise_wr = write_strobe && (wr_type == REG_TONE) && (wr_ch == 2'(NOISE_CH));

  // Byte-wide register writes; reset takes priority over a coincident strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 4; i++)         attn[i]      <= 4'hF;
      for (int i = 0; i < NUM_TONES; i++) tone_freq[i] <= '0;
      noise_ctrl <= '0;
      latch_ch   <= '0;
      latch_type <= REG_TONE;
    end else if (write_strobe) begin
      if (is_latch) begin
        latch_ch   <= wr_ch;
        latch_type <= wr_type;
      end
      if (wr_type == REG_VOLUME) begin
        attn[wr_ch] <= data_in[3:0];
      end else if (wr_ch == 2'(NOISE_CH)) begin
        noise_ctrl <= data_in[2:0];
      end else begin
        for (int i = 0; i < NUM_TONES; i++) begin
          if (wr_ch == 2'(i)) begin
            if (is_latch) tone_freq[i][3:0] <= data_in[3:0];
            else          tone_freq[i][9:4] <= data_in[5:0];
          end
        end
      end
    end
  end

  // ------------------------------------------------------------ tone channels
  logic [NUM_TONES-1:0] tone_state;
  logic [NUM_TONES-1:0] tone_rise;
  logic [1:0]           unused_tone_rise;

  // Only tone 2 drives the noise clock; the other edge outputs are left idle.
  assign unused_tone_rise = tone_rise[1:0];

  for (genvar g = 0; g < NUM_TONES; g++) begin : g_tone
    psg_tone_channel #(.PERIOD_BITS(TONE_BITS)) u_tone (
      .clk    (clk),
      .reset  (reset),
      .tick   (tick),
      .period (tone_freq[g]),
      .state  (tone_state[g]),
      .rise   (tone_rise[g])
    );
  end

  // ------------------------------------------------------------ noise channel
  noise_rate_e          noise_rate;
  logic [TONE_BITS-1:0] noise_half;
  logic                 unused_noise_ff;
  logic                 noise_rise;
  logic                 shift_en;
  logic                 feedback;
  logic [LFSR_BITS-1:0] lfsr;

  assign noise_rate = noise_rate_e'(noise_ctrl[1:0]);
  assign noise_half = noise_period(noise_rate);

  // The rate flip-flop itself is never output; only its 0->1 edge matters.
  psg_tone_channel #(.PERIOD_BITS(TONE_BITS)) u_noise_rate (
    .clk    (clk),
    .reset  (reset),
    .tick   (tick),
    .period (noise_half),
    .state  (unused_noise_ff),
    .rise   (noise_rise)
  );

  assign shift_en = (noise_rate == RATE_TONE2) ? tone_rise[2] : noise_rise;
  assign feedback = noise_ctrl[2] ? ^(lfsr & LFSR_TAP_MASK) : lfsr[0];

  // Shift register; a noise_ctrl write reseeds and overrides a coincident shift.
  always_ff @(posedge clk) begin
    if (reset)         lfsr <= LFSR_SEED;
    else if (noise_wr) lfsr <= LFSR_SEED;
    else if (shift_en) lfsr <= {feedback, lfsr[LFSR_BITS-1:1]};
  end

  // ---------------------------------------------------------------- amplitude
  logic [W-1:0] lut [16];
  logic [3:0]   chan_state;

  for (genvar k = 0; k < 16; k++) begin : g_lut
    assign lut[k] = W'(attn_lut(k, W));
  end

  assign chan_state = {lfsr[0], tone_state};

  // Gate each channel's attenuated level by its square/noise state.
  always_comb begin
    channel_out = '0;
    for (int i = 0; i < 4; i++) begin
      if (chan_state[i]) channel_out[i*W +: W] = lut[attn[i]];
    end
  end

  // --------------------------------------------------------------------- mix
  logic [MW-1:0] mix_sum;

  // Two extra bits cover the sum of four full-scale channels.
  always_comb begin
    mix_sum = '0;
    for (int i = 0; i < 4; i++) mix_sum = mix_sum + MW'(channel_out[i*W +: W]);
  end

  // Registered mix output.
  always_ff @(posedge clk) begin
    if (reset) mix_out <= '0;
    else       mix_out <= mix_sum;
  end

endmodule

// File: tb/tb_psg_sn76489_core.sv
// Bench for psg_sn76489_core: event-time model of the PSG compared every cycle
// against a CLOCK_DIV=1 instance, plus a CLOCK_DIV=16 instance for the prescaler.
module tb_psg_sn76489_core;

  localparam int W = 8;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [7:0]     data_in = 8'h00;
  logic           write_strobe = 1'b0;
  logic           tick1, tick16;
  logic [4*W-1:0] ch1, ch16;
  logic [W+1:0]   mix1, mix16;

  always #5 clk = ~clk;

  psg_sn76489_core #(.CLOCK_DIV(1)) dut1 (
    .clk(clk), .reset(reset), .data_in(data_in), .write_strobe(write_strobe),
    .tick(tick1), .channel_out(ch1), .mix_out(mix1));

  psg_sn76489_core #(.CLOCK_DIV(16)) dut16 (
    .clk(clk), .reset(reset), .data_in(data_in), .write_strobe(write_strobe),
    .tick(tick16), .channel_out(ch16), .mix_out(mix16));

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // ------------------------------------------------------------------ model
  // Tones and the noise flip-flop are tracked as "tick index of next toggle"
  // rather than as counters.
  int lut_ref [16] = '{255, 203, 161, 128, 102, 81, 64, 51, 40, 32, 26, 20, 16, 13, 10, 0};

  int          m_valid = 0;
  longint      m_t;
  int          m_attn [4];
  int          m_freq [3];
  int          m_tstate [3];
  longint      m_tnext [3];
  int          m_nctrl, m_lch, m_ltype;
  int          m_nff;
  longint      m_nnext;
  int unsigned m_lfsr;
  int          m_mix;
  int          m_k16;
  int          m_shifts = 0;

  function automatic int exp_ch(input int i);
    int st;
    st = (i < 3) ? m_tstate[i] : int'(m_lfsr & 1);
    return (st != 0) ? lut_ref[m_attn[i]] : 0;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_valid = 1;
      m_t = 0;
      for (int i = 0; i < 4; i++) m_attn[i] = 15;
      for (int i = 0; i < 3; i++) begin m_freq[i] = 0; m_tstate[i] = 0; m_tnext[i] = 0; end
      m_nctrl = 0; m_lch = 0; m_ltype = 0;
      m_nff = 0; m_nnext = 0;
      m_lfsr = 32'h8000;
      m_mix = 0;
      m_k16 = 0;
    end else begin
      int old_t2, nrise, n_half, fb, do_shift;
      m_k16++;
      m_mix = exp_ch(0) + exp_ch(1) + exp_ch(2) + exp_ch(3);
      old_t2 = m_tstate[2];
      for (int i = 0; i < 3; i++) begin
        if (m_freq[i] <= 1) begin
          m_tstate[i] = 1;
          m_tnext[i] = m_t + 1;
        end else if (m_t >= m_tnext[i]) begin
          m_tstate[i] ^= 1;
          m_tnext[i] = m_t + m_freq[i];
        end
      end
      n_half = ((m_nctrl & 3) == 1) ? 32 : ((m_nctrl & 3) == 2) ? 64 : 16;
      nrise = 0;
      if (m_t >= m_nnext) begin
        nrise = (m_nff == 0) ? 1 : 0;
        m_nff ^= 1;
        m_nnext = m_t + n_half;
      end
      do_shift = ((m_nctrl & 3) == 3) ? int'(old_t2 == 0 && m_tstate[2] == 1) : nrise;
      if (do_shift != 0) begin
        fb = ((m_nctrl & 4) != 0) ? ($countones(m_lfsr & 32'h9) & 1) : int'(m_lfsr & 1);
        m_lfsr = (fb << 15) | (m_lfsr >> 1);
        m_shifts++;
      end
      m_t++;
      if (write_strobe) begin
        if (data_in[7]) begin m_lch = int'(data_in[6:5]); m_ltype = int'(data_in[4]); end
        if (m_ltype == 1) m_attn[m_lch] = int'(data_in[3:0]);
        else if (m_lch == 3) begin m_nctrl = int'(data_in[2:0]); m_lfsr = 32'h8000; end
        else if (data_in[7]) m_freq[m_lch] = (m_freq[m_lch] & 'h3F0) | int'(data_in[3:0]);
        else m_freq[m_lch] = (m_freq[m_lch] & 'hF) | (int'(data_in[5:0]) << 4);
      end
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (m_valid != 0) begin
      for (int i = 0; i < 4; i++)
        check($sformatf("ch%0d", i), longint'(ch1[i*W +: W]), exp_ch(i));
      check("mix", longint'(mix1), m_mix);
      check("tick_div1", longint'(tick1), 1);
      check("tick_div16", longint'(tick16), (m_k16 % 16 == 15) ? 1 : 0);
    end
  end

  task automatic wr(input logic [7:0] b);
    data_in = b;
    write_strobe = 1'b1;
    @(negedge clk);
    write_strobe = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // --------------------------------------------------------------- stimulus
  initial begin
    int n, found, cnt, s0;

    // 1: reset state and prescaler
    repeat (3) @(negedge clk);
    check("rst_ch_div1", longint'(ch1), 0);
    check("rst_mix_div1", longint'(mix1), 0);
    check("rst_ch_div16", longint'(ch16), 0);
    check("rst_mix_div16", longint'(mix16), 0);
    check("rst_tick_div16", longint'(tick16), 0);
    check("model_seed", m_lfsr, 32'h8000);
    reset = 1'b0;
    n = 0; found = 0;
    for (int c = 1; c <= 40 && found == 0; c++) begin
      @(negedge clk);
      if (tick16) begin found = 1; n = c; end
    end
    check("tick16_first", n, 15);
    n = 0; found = 0;
    for (int c = 1; c <= 40 && found == 0; c++) begin
      @(negedge clk);
      if (tick16) begin found = 1; n = c; end
    end
    check("tick16_spacing", n, 16);

    // 2: tone 0, half-period 5, full volume
    wr(8'h85); wr(8'h00); wr(8'h90);
    repeat (3) @(negedge clk);
    check("t2_low", longint'(ch1[7:0]), 0);
    @(negedge clk);
    check("t2_high", longint'(ch1[7:0]), 255);
    check("t2_mix_lag", longint'(mix1), 0);
    @(negedge clk);
    check("t2_mix", longint'(mix1), 255);
    repeat (4) @(negedge clk);
    check("t2_low_again", longint'(ch1[7:0]), 0);
    repeat (40) @(negedge clk);

    // 3: attenuation, silence, forced-high
    wr(8'h93);
    n = 0;
    for (int c = 0; c < 20 && n == 0; c++) begin
      @(negedge clk);
      n = int'(ch1[7:0]);
    end
    check("t3_attn3", n, 128);
    wr(8'h9F);
    cnt = 0;
    for (int c = 0; c < 12; c++) begin @(negedge clk); if (ch1[7:0] == 8'd0) cnt++; end
    check("t3_silent", cnt, 12);
    wr(8'h81); wr(8'h00); wr(8'h90);
    cnt = 0;
    for (int c = 0; c < 20; c++) begin @(negedge clk); if (ch1[7:0] == 8'd255) cnt++; end
    check("t3_forced_high", cnt, 20);

    // 4: periodic noise, rate 16
    wr(8'hF0); wr(8'hE0);
    check("t4_seed", m_lfsr, 32'h8000);
    check("t4_noise_low", longint'(ch1[31:24]), 0);
    found = 0;
    for (int c = 0; c < 1200 && found == 0; c++) begin
      @(negedge clk);
      if (ch1[31:24] != 8'd0) found = 1;
    end
    check("t4_rise_seen", found, 1);
    check("t4_level", longint'(ch1[31:24]), 255);
    cnt = 1;
    for (int c = 0; c < 100 && ch1[31:24] != 8'd0; c++) begin
      @(negedge clk);
      if (ch1[31:24] != 8'd0) cnt++;
    end
    check("t4_high_len", cnt, 32);
    n = cnt;
    for (int c = 0; c < 700 && ch1[31:24] == 8'd0; c++) begin
      @(negedge clk);
      n++;
    end
    check("t4_period", n, 512);

    // 5: white noise, then tone-2-driven rate
    wr(8'hC8); wr(8'h00);
    wr(8'hE4);
    check("t5_seed", m_lfsr, 32'h8000);
    s0 = m_shifts;
    for (int c = 0; c < 700 && (m_shifts - s0) < 16; c++) @(negedge clk);
    check("t5_lfsr_16", m_lfsr, 32'h9000);
    repeat (600) @(negedge clk);
    wr(8'hE7);
    check("t5_reseed", m_lfsr, 32'h8000);
    s0 = m_shifts;
    repeat (160) @(negedge clk);
    check("t5_tone2_shifts", m_shifts - s0, 10);
    check("t5_lfsr_10", m_lfsr, 32'h0020);
    repeat (400) @(negedge clk);
    wr(8'hE7);
    check("t5_reseed_again", m_lfsr, 32'h8000);
    repeat (300) @(negedge clk);

    // 6: reset during a write
    wr(8'h85); wr(8'h00);
    repeat (7) @(negedge clk);
    reset = 1'b1;
    data_in = 8'h83;
    write_strobe = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    write_strobe = 1'b0;
    check("t6_ch", longint'(ch1), 0);
    check("t6_mix", longint'(mix1), 0);
    check("t6_tick16", longint'(tick16), 0);
    wr(8'h90);
    cnt = 0;
    for (int c = 0; c < 10; c++) begin @(negedge clk); if (ch1[7:0] == 8'd255) cnt++; end
    check("t6_write_dropped", cnt, 10);
    repeat (5) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/psg_sn76489_core.md
Name: psg_sn76489_core

Overview:
Full-function SN76489 programmable sound generator core: 3 tone channels + 1 noise channel.
- Programmed through the chip's native byte-wide latch/data write protocol.
- Master-clock prescaler, logarithmic attenuation LUT, configurable noise LFSR taps.
- Outputs per-channel amplitudes and a registered mix; sits under the tt_um top, which drives data_in/write_strobe from ui_in/uio_in.

Parameters:
CLOCK_DIV, 16, master clocks per generator tick (>=1)
CHANNEL_OUTPUT_BITS, 8, per-channel amplitude width W
LFSR_BITS, 16, noise shift-register width
LFSR_TAP_MASK, 16'h0009, bits XORed for white-noise feedback (SMS taps)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
data_in  in  8  write byte
write_strobe  in  1  one-cycle byte-valid qualifier
tick  out  1  prescaler tick (debug)
channel_out  out  4*W  channel i in bits [i*W +: W]; i=3 is noise
mix_out  out  W+2  registered sum of the four channels

Behaviour:
Reset:
- attn[0..3]=15 (silent); tone_freq[0..2]=0; noise_ctrl=0.
- latched channel/type=0; prescaler=0; all counters=0; tone states=0.
- lfsr=1<<(LFSR_BITS-1); mix_out=0; channel_out=0.

Prescaler:
- Counts 0..CLOCK_DIV-1; tick=1 in the cycle it equals CLOCK_DIV-1.
- CLOCK_DIV=1 gives tick every cycle.

Writes (on write_strobe; register updates visible the next cycle):
- Latch byte (bit7=1): ch=bits6:5, type=bit4 (1=volume), both stored.
  - volume: attn[ch]=bits3:0.
  - tone (ch<3): tone_freq[ch][3:0]=bits3:0.
  - noise (ch=3): noise_ctrl=bits2:0.
- Data byte (bit7=0), uses the stored ch/type:
  - volume: attn=bits3:0.
  - tone: tone_freq[ch][9:4]=bits5:0.
  - noise: noise_ctrl=bits2:0.
- Any write to noise_ctrl reloads lfsr to the seed in the same cycle as the register update.
- Writes without strobe are ignored; a write on a tick cycle still lets that tick proceed using the old values.

Tone channel (on tick):
- If tone_freq<=1: state forced 1, counter held at 0.
- Else if counter==0: counter=tone_freq-1, state toggles.
- Else: counter decrements.
- Half-period = tone_freq ticks. A new freq takes effect at the next reload.

Noise (on tick):
- Rate from noise_ctrl[1:0]: 00/01/10 give half-period N=16/32/64 ticks from its own down-counter, same reload rule as tone. The LFSR shifts on each 0->1 toggle of the internal flip-flop, i.e. every 2N ticks.
- Rate 11: LFSR shifts on the tick where tone 2 state goes 0->1.
- Shift: lfsr = {fb, lfsr[LFSR_BITS-1:1]}.
  - fb = parity(lfsr & LFSR_TAP_MASK) if noise_ctrl[2] (white).
  - fb = lfsr[0] otherwise (periodic).
- Noise state = lfsr[0].

Amplitude:
- channel_out[i] = state_i ? LUT[attn_i] : 0 (combinational from registers).
- LUT[k] = round((2^W-1)*10^(-k/10)) for k<15; LUT[15]=0. For W=8: 255,203,161,128,102,81,64,51,40,32,26,20,16,13,10,0.

Mix:
- mix_out <= zero-extended sum of the 4 channels, 1-cycle latency, never overflows.

Reset mid-operation overrides any write in the same cycle.

Decomposition:
- psg_pkg: latch/data field positions, noise rate constants (16/32/64), attenuation LUT function of (k, W), LFSR seed function.
- Sub-module psg_tone_channel: prescaled down-counter + state, forced-high rule. Instanced 3x; the noise rate counter reuses it with compare from the rate decode.

Test Plan:
1. Reset, CLOCK_DIV=16 -> channel_out=0, mix_out=0, tick every 16 cycles from the cycle after reset deasserts.
2. CLOCK_DIV=1; write 0x85,0x00,0x90 -> channel0 alternates 255/0 every 5 cycles; mix_out mirrors it 1 cycle later.
3. Tone as in 2, then 0x93 -> amplitude 128; 0x9F -> 0; 0x81,0x00 -> constant 255 (freq=1 forced high).
4. Write 0xE0 (periodic, rate 16), 0xF0 -> lfsr seed 0x8000; noise output 255 for one shift in every 16, shifts spaced 32 ticks.
5. Write 0xE4 then 0xE7 with tone2 freq 8 -> white sequence matches golden parity model; with rate 11, one shift per 16 ticks. Rewriting 0xE7 reseeds the lfsr.
6. Assert reset mid-tone with write_strobe high -> write dropped, all registers return to reset values next cycle.
